alu_iter_exec: RTL and testbench

- Parametrised, sequential successor to the combinational ALU opcode decoder.
- Decodes the 4-bit ALU opcode and executes the operation on WIDTH-bit operands.
- Single-cycle ops complete in one cycle. Shifts and multiply are iterative, one step per cycle.
- Sits in the EX stage of the multicycle datapath. Valid/ready handshakes on both sides let the control FSM stall on long ops.

---
 rtl/alu_iter_exec.sv | 181 ++++++++++++++++++
 tb/tb_alu_iter_exec.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_exec.sv
// EX-stage ALU: single-cycle logic/arithmetic ops plus iterative shifts and
// shift-add multiply, with valid/ready handshakes on request and result sides.
module alu_iter_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    // Counter must hold WIDTH itself for the multiply step count.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_ORR = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1010;
    localparam logic [3:0] OP_LSR = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_MUL   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         opc_q, opc_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic [SHAMT_W-1:0] shamt;
    logic               is_shift;
    logic [WIDTH-1:0]   shift_step;
    logic [WIDTH-1:0]   mul_step;
    logic               last_step;

    function automatic logic is_legal(input logic [3:0] opc);
        case (opc)
            OP_ADD, OP_XOR, OP_SUB, OP_AND, OP_ORR,
            OP_LSL, OP_LSR, OP_MUL: is_legal = 1'b1;
            default:                is_legal = 1'b0;
        endcase
    endfunction

    // Shifts only reach here with a zero shift amount, so they pass A through.
    function automatic logic [WIDTH-1:0] alu_single(input logic [3:0]       opc,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        case (opc)
            OP_ADD:         alu_single = a + b;
            OP_XOR:         alu_single = a ^ b;
            OP_SUB:         alu_single = a - b;
            OP_AND:         alu_single = a & b;
            OP_ORR:         alu_single = a | b;
            OP_LSL, OP_LSR: alu_single = a;
            default:        alu_single = '0;
        endcase
    endfunction

    assign shamt      = op_b[SHAMT_W-1:0];
    assign is_shift   = (opcode == OP_LSL) || (opcode == OP_LSR);
    assign shift_step = (opc_q == OP_LSL) ? (acc_q << 1) : (acc_q >> 1);
    assign mul_step   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step  = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    opc_d = opcode;
                    if (is_shift && (shamt != '0)) begin
                        state_d = S_SHIFT;
                        cnt_d   = CNT_W'(shamt);
                        acc_d   = op_a;
                    end else if (opcode == OP_MUL) begin
                        state_d  = S_MUL;
                        cnt_d    = CNT_W'(WIDTH);
                        acc_d    = '0;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                    end else begin
                        state_d   = S_DONE;
                        result_d  = alu_single(opcode, op_a, op_b);
                        zero_d    = (alu_single(opcode, op_a, op_b) == '0);
                        illegal_d = !is_legal(opcode);
                    end
                end
            end
            S_SHIFT: begin
                acc_d = shift_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) begin
                    state_d   = S_DONE;
                    result_d  = shift_step;
                    zero_d    = (shift_step == '0);
                    illegal_d = 1'b0;
                end
            end
            S_MUL: begin
                acc_d    = mul_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (last_step) begin
                    state_d   = S_DONE;
                    result_d  = mul_step;
                    zero_d    = (mul_step == '0);
                    illegal_d = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec at WIDTH=32 with hand-computed expectations.
module tb_alu_iter_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_iter_exec #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, then count edges (accept edge = 1) until out_valid.
    task automatic run_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int lowcnt);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        opcode    = opc;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode   = 4'b0000;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h0000_0001;
        lat      = 1;
        lowcnt   = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) lowcnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int low;
        int guard;
        int ov_seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 4'b0000;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_illegal", illegal, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, lat, low);
        check("add_ov", out_valid, 1);
        check("add_lat", lat, 1);
        check("add_res", result, 32'h0000_0000);
        check("add_zero", zero, 1);
        check("add_ill", illegal, 0);

        run_op(4'b0010, 32'd5, 32'd7, lat, low);
        check("sub_res", result, 32'hFFFF_FFFE);
        check("sub_zero", zero, 0);

        run_op(4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, low);
        check("xor_res", result, 32'hFF00_0FF0);
        run_op(4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, low);
        check("and_res", result, 32'h00F0_000F);
        run_op(4'b1000, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, low);
        check("orr_res", result, 32'hFFF0_0FFF);

        run_op(4'b1010, 32'h0000_0001, 32'h0000_0023, lat, low);
        check("lsl_res", result, 32'h0000_0008);
        check("lsl_lat", lat, 4);
        check("lsl_ready_low", low, 3);

        run_op(4'b1011, 32'h8000_0000, 32'd31, lat, low);
        check("lsr_res", result, 32'h0000_0001);
        check("lsr_lat", lat, 32);

        run_op(4'b1010, 32'h1234_5678, 32'h0000_0040, lat, low);
        check("lsl0_res", result, 32'h1234_5678);
        check("lsl0_lat", lat, 1);

        run_op(4'b1100, 32'h0001_0003, 32'h0001_0005, lat, low);
        check("mul_res", result, 32'h0008_000F);
        check("mul_lat", lat, 33);
        run_op(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, low);
        check("mul_ff_res", result, 32'h0000_0001);
        check("mul_ff_zero", zero, 0);

        run_op(4'b0111, 32'h1234_5678, 32'h9ABC_DEF0, lat, low);
        check("ill_res", result, 32'h0000_0000);
        check("ill_flag", illegal, 1);
        check("ill_zero", zero, 1);
        check("ill_lat", lat, 1);
        run_op(4'b0000, 32'd2, 32'd3, lat, low);
        check("post_ill_res", result, 32'd5);
        check("post_ill_flag", illegal, 0);

        // Reset ten steps into a multiply.
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        opcode   = 4'b1100;
        op_a     = 32'd3;
        op_b     = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mul_mid_busy", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle", busy, 0);
        @(posedge clk);
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        ov_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) ov_seen++;
        end
        check("abort_no_result", ov_seen, 0);

        // Backpressure: hold result while a second request waits.
        @(negedge clk);
        opcode    = 4'b0000;
        op_a      = 32'd10;
        op_b      = 32'd20;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        opcode = 4'b0001;
        op_a   = 32'h0000_00FF;
        op_b   = 32'h0000_000F;
        check("bp_ov", out_valid, 1);
        check("bp_res0", result, 32'd30);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_ov", out_valid, 1);
            check("bp_hold_res", result, 32'd30);
            check("bp_hold_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_ov", out_valid, 0);
        check("bp_hs_ready", in_ready, 1);
        check("bp_hs_res", result, 32'd30);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_next_ov", out_valid, 1);
        check("bp_next_res", result, 32'h0000_00F0);
        @(posedge clk);
        #1;
        check("bp_final_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
